// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, selects sequential or redirected next PC,
// and fetches through a single-outstanding request/response memory port.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        FetchValidF
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HAVE} state_t;

  state_t      state, state_nxt;
  logic        drop, drop_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_buf, instr_buf_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;
  assign target   = PCTargetE & ~32'd3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      drop      <= 1'b0;
      pc        <= RESET_PC;
      instr_buf <= NOP;
    end else begin
      state     <= state_nxt;
      drop      <= drop_nxt;
      pc        <= pc_nxt;
      instr_buf <= instr_buf_nxt;
    end
  end

  // A redirect always rewrites the PC; drop marks a response already in flight as stale.
  always_comb begin
    state_nxt     = state;
    drop_nxt      = drop;
    pc_nxt        = pc;
    instr_buf_nxt = instr_buf;
    case (state)
      BOOT: begin
        state_nxt = REQ;
        if (PCSrcE) pc_nxt = target;
      end
      REQ: begin
        if (PCSrcE) pc_nxt = target;
        if (imem_ready) begin
          state_nxt = WAIT;
          if (PCSrcE) drop_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (PCSrcE) pc_nxt = target;
        if (imem_rvalid) begin
          drop_nxt = 1'b0;
          if (drop || PCSrcE) begin
            state_nxt = REQ;
          end else begin
            instr_buf_nxt = imem_rdata;
            state_nxt     = HAVE;
          end
        end else if (PCSrcE) begin
          drop_nxt = 1'b1;
        end
      end
      HAVE: begin
        if (PCSrcE) begin
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (!StallF) begin
          pc_nxt    = pc_plus4;
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign PCF         = pc;
  assign PCplus4F    = pc_plus4;
  assign FetchValidF = (state == HAVE);
  assign InstrF      = (state == HAVE) ? instr_buf : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable memory responder.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCplus4F;
  logic        FetchValidF;

  int          check_count = 0;
  int          pass_count  = 0;
  int          mem_lat     = 1;
  int          pend_cnt    = 0;
  logic [31:0] pend_addr   = 32'h0;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCplus4F    (PCplus4F),
    .FetchValidF (FetchValidF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0000_0000: memWord = 32'h0050_0093;
      32'h0000_0004: memWord = 32'h0010_0113;
      default:       memWord = 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // One clock: drive inputs, let the memory model see the handshake, settle #1 after the edge.
  task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] tgt);
    logic        hs;
    logic [31:0] a;
    StallF    = stall;
    PCSrcE    = redirect;
    PCTargetE = tgt;
    hs = imem_req && imem_ready;
    a  = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (hs) begin
      pend_addr = a;
      pend_cnt  = mem_lat;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(pend_addr);
      end
    end
    StallF    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_pcf"},   PCF,         32'h0);
    checkOutput({tag, "_pc4"},   PCplus4F,    32'h4);
    checkOutput({tag, "_addr"},  imem_addr,   32'h0);
    checkOutput({tag, "_req"},   imem_req,    1'b0);
    checkOutput({tag, "_instr"}, InstrF,      NOP);
    checkOutput({tag, "_valid"}, FetchValidF, 1'b0);
  endtask

  initial begin
    reset_n     = 1'b0;
    StallF      = 1'b0;
    PCSrcE      = 1'b0;
    PCTargetE   = 32'h0;
    imem_ready  = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    checkReset("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back fetches at 0 and 4
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_req0",   imem_req,    1'b1);
    checkOutput("t1_addr0",  imem_addr,   32'h0);
    checkOutput("t1_nop0",   InstrF,      NOP);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_wait_req", imem_req,  1'b0);
    checkOutput("t1_wait_v",   FetchValidF, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_v0",     FetchValidF, 1'b1);
    checkOutput("t1_pc0",    PCF,         32'h0);
    checkOutput("t1_instr0", InstrF,      32'h0050_0093);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_addr4",  imem_addr,   32'h4);
    checkOutput("t1_nop4",   InstrF,      NOP);
    checkOutput("t1_v4req",  FetchValidF, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_v4",     FetchValidF, 1'b1);
    checkOutput("t1_pc4",    PCF,         32'h4);
    checkOutput("t1_instr4", InstrF,      32'h0010_0113);

    // Fetch PC 8, then stall for 3 cycles with a stray rvalid that must be ignored
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_addr8", imem_addr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_pc8", PCF, 32'h8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      checkOutput($sformatf("t3_stall_pc%0d", i),    PCF,         32'h8);
      checkOutput($sformatf("t3_stall_instr%0d", i), InstrF,      memWord(32'h8));
      checkOutput($sformatf("t3_stall_req%0d", i),   imem_req,    1'b0);
      checkOutput($sformatf("t3_stall_v%0d", i),     FetchValidF, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_req12",  imem_req,  1'b1);
    checkOutput("t3_addr12", imem_addr, 32'hC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_instr12", InstrF, memWord(32'hC));

    // Redirect while waiting on PC 16 with a two-cycle response
    mem_lat = 2;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_addr16", imem_addr, 32'h10);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40);
    checkOutput("t4_addr40",   imem_addr,   32'h40);
    checkOutput("t4_v_redir",  FetchValidF, 1'b0);
    checkOutput("t4_req_wait", imem_req,    1'b0);
    mem_lat = 1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_v_stale", FetchValidF, 1'b0);
    checkOutput("t4_req40",   imem_req,    1'b1);
    checkOutput("t4_reqaddr", imem_addr,   32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t4_v40",     FetchValidF, 1'b1);
    checkOutput("t4_pc40",    PCF,         32'h40);
    checkOutput("t4_instr40", InstrF,      memWord(32'h40));

    // Redirect to a misaligned target in the same cycle the response arrives
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_rvalid_here", imem_rvalid, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h103);
    checkOutput("t5_req",   imem_req,    1'b1);
    checkOutput("t5_addr",  imem_addr,   32'h100);
    checkOutput("t5_v",     FetchValidF, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_instr", InstrF, memWord(32'h100));

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("t6_addr",   imem_addr, 32'hFFFF_FFFC);
    checkOutput("t6_pc4req", PCplus4F,  32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_pc",    PCF,         32'hFFFF_FFFC);
    checkOutput("t6_pc4",   PCplus4F,    32'h0);
    checkOutput("t6_v",     FetchValidF, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset in the middle of WAIT
    mem_lat = 2;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t7_in_wait", imem_req, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkReset("t7_rst");
    pend_cnt    = 0;
    imem_rvalid = 1'b0;
    mem_lat     = 1;

    // Memory refuses for 4 cycles after a fresh reset
    imem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_req%0d", i),   imem_req,  1'b1);
      checkOutput($sformatf("t2_addr%0d", i),  imem_addr, 32'h0);
      checkOutput($sformatf("t2_instr%0d", i), InstrF,    NOP);
      applyStimulus(1'b0, 1'b0, 32'h0);
    end
    imem_ready = 1'b1;
    checkOutput("t2_req4",  imem_req,  1'b1);
    checkOutput("t2_addr4", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t2_wait_nop", InstrF, NOP);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t2_v",     FetchValidF, 1'b1);
    checkOutput("t2_instr", InstrF,      32'h0050_0093);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the IF/ID pipeline register. Owns the PC register and the next-PC selection: sequential PC+4, or branch/jump target from EX. Fetches instructions through a variable-latency, single-outstanding request/response memory port. Drives InstrF, PCF and PCplus4F into IF/ID, and inserts a NOP bubble whenever no fetched instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- NOP, 32'h0000_0013, instruction driven on InstrF when no valid instruction (addi x0,x0,0)

- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- StallF  in  1  hazard unit hold; 1 = keep current fetched instruction and PC
- PCSrcE  in  1  redirect request from EX (taken branch / jal / jalr)
- PCTargetE  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (bits [1:0] always 0)
- imem_ready  in  1  memory accepts request this cycle (imem_req && imem_ready)
- imem_rvalid  in  1  response valid, earliest 1 cycle after acceptance
- imem_rdata  in  32  response instruction
- InstrF  out  32  instruction to IF/ID (NOP when FetchValidF=0)
- PCF  out  32  PC of instruction in fetch
- PCplus4F  out  32  PCF + 4
- FetchValidF  out  1  InstrF holds a real fetched instruction

## Operation
- States: BOOT, REQ, WAIT, HAVE. A 1-bit drop flag marks the outstanding response as stale.
- BOOT: entered on reset. imem_req=0. Next cycle goes to REQ.
- REQ: imem_req=1, imem_addr=PCF. On imem_ready, go to WAIT. imem_addr may change before acceptance; memory samples only on handshake.
- WAIT: imem_req=0. On imem_rvalid with drop=0: latch imem_rdata into the instruction buffer, go to HAVE. On imem_rvalid with drop=1: discard data, clear drop, go to REQ.
- HAVE: FetchValidF=1, InstrF=buffer. If StallF=0: PCF<=PCplus4F, go to REQ. If StallF=1: hold state and buffer.
- InstrF=NOP and FetchValidF=0 in BOOT, REQ and WAIT. IF/ID therefore captures bubbles while memory is busy.
- Redirect (PCSrcE=1) has priority over StallF and sequential advance. In every state it sets PCF<=PCTargetE with bits [1:0] cleared.
  - REQ, not accepted this cycle: remain in REQ; the next request uses the new PC.
  - REQ, accepted this cycle: go to WAIT with drop=1.
  - WAIT, no rvalid: drop<=1.
  - WAIT, rvalid same cycle: data discarded, go to REQ, drop=0.
  - HAVE: buffer discarded, go to REQ.
  - BOOT: PCF updated, go to REQ.
- A repeated redirect while drop=1 updates PCF only. Only one response is ever outstanding.
- imem_rvalid outside WAIT is ignored.
- PCplus4F = PCF + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (reset_n=0, asynchronous) forces: state=BOOT, drop=0, PCF=RESET_PC, PCplus4F=RESET_PC+4, imem_addr=RESET_PC, imem_req=0, InstrF=NOP, FetchValidF=0.
- Reset mid-transaction abandons the outstanding request. The memory side shares reset_n, so no late response is expected.
- First imem_req rises 1 cycle after reset_n deasserts (BOOT → REQ).
- Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, HAVE), with imem_ready=1 and 1-cycle response latency.
- A redirect in cycle t gives imem_addr=target from cycle t+1. It costs one extra full REQ/WAIT round trip only if a stale response is pending.
- All outputs are registered or decoded from state/registers only. There are no combinational paths from imem_* or PCSrcE to outputs.

## Test plan
- Reset release, RESET_PC=0, memory ready=1, latency 1, returning 32'h00500093 then 32'h00100113 → imem_addr 0 then 4. FetchValidF pulses with PCF=0/4, InstrF as returned, NOP in between.
- Memory holds imem_ready=0 for 4 cycles, then 1 → imem_req and imem_addr=0 stable all 5 cycles. InstrF=NOP until the response.
- In HAVE with PCF=8, StallF=1 for 3 cycles → PCF=8 and InstrF unchanged, no new request. StallF=0 → next imem_addr=12.
- In WAIT for PC=16, PCSrcE=1 with PCTargetE=32'h40 → the response for 16 is discarded (FetchValidF stays 0). Next request is addr 0x40, and FetchValidF comes with PCF=0x40.
- PCSrcE=1, PCTargetE=32'h103, in the same cycle that imem_rvalid arrives → data dropped, next imem_addr=32'h100.
- PCF=32'hFFFF_FFFC fetched, StallF=0 → PCplus4F=0, next imem_addr=0. Assert reset_n=0 during WAIT → outputs return to reset values immediately.
